// File: rtl/mult_pkg.sv
// Shared constants and Wallace-tree sizing helpers for the pipelined multiplier.
// Row counts start at WIDTH+1: one row per multiplier bit plus the sign-fix constant row.
package mult_pkg;

   localparam logic MODE_UNSIGNED = 1'b0;
   localparam logic MODE_SIGNED   = 1'b1;

   function automatic int csa_rows(input int n);
      return 2 * (n / 3) + n % 3;
   endfunction

   function automatic int rows_at(input int width, input int layer);
      int n;
      n = width + 1;
      for (int i = 0; i < layer; i++) n = csa_rows(n);
      return n;
   endfunction

   function automatic int wallace_layers(input int width);
      int n;
      int l;
      n = width + 1;
      l = 0;
      while (n > 2) begin
         n = csa_rows(n);
         l++;
      end
      return l;
   endfunction

   // A cut registers the rows entering the given layer.
   function automatic bit is_cut(input int width, input int stages,
                                 input int layer);
      int nl;
      nl = wallace_layers(width);
      for (int k = 1; k < stages; k++)
         if ((k * nl) / stages == layer) return 1'b1;
      return 1'b0;
   endfunction

endpackage

// File: rtl/csa_row.sv
// Width-agnostic 3:2 compressor row; carry is returned already shifted left.
// The carry out of the top full adder falls beyond the product width.
module csa_row #(
   parameter int N = 8
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic [N-1:0] c_i,
   output logic [N-1:0] sum_o,
   output logic [N-1:0] cry_o
);

   assign sum_o = a_i ^ b_i ^ c_i;

   assign cry_o[0]     = 1'b0;
   assign cry_o[N-1:1] = (a_i[N-2:0] & b_i[N-2:0])
                       | (a_i[N-2:0] & c_i[N-2:0])
                       | (b_i[N-2:0] & c_i[N-2:0]);

endmodule

// File: rtl/wallace_mult_pipe.sv
// Pipelined Wallace-tree multiplier, unsigned or Baugh-Wooley signed per transaction.
// One global advance moves every stage; the final carry-propagate add feeds the output register.
module wallace_mult_pipe
   import mult_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 3,
   parameter int TAG_W  = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_signed,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_prod,
   output logic [TAG_W-1:0]   out_tag,
   output logic               busy
);

   localparam int PW = 2 * WIDTH;
   localparam int R0 = WIDTH + 1;
   localparam int NL = wallace_layers(WIDTH);
   localparam int TW = STAGES * TAG_W;
   localparam logic [PW-1:0] BW_K =
      (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

   logic                           adv;
   logic [STAGES-1:0]              v_q;
   logic [STAGES-1:0]              v_d;
   logic [STAGES-1:0][TAG_W-1:0]   tag_q;
   logic [STAGES-1:0][TAG_W-1:0]   tag_d;
   logic [PW-1:0]                  prod_q;
   logic [PW-1:0]                  prod_d;
   logic [PW-1:0]                  pp [R0];

   assign adv      = !v_q[STAGES-1] || out_ready;
   assign in_ready = adv;

   assign v_d   = STAGES'({v_q, in_valid});
   assign tag_d = TW'({tag_q, in_tag});

   // Signed rows invert the terms pairing exactly one operand MSB.
   for (genvar i = 0; i < WIDTH; i++) begin : g_pp
      localparam logic [WIDTH-1:0] INV = (i == WIDTH - 1)
         ? {1'b0, {(WIDTH-1){1'b1}}}
         : {1'b1, {(WIDTH-1){1'b0}}};
      logic [WIDTH-1:0] bits;
      assign bits = (in_a & {WIDTH{in_b[i]}})
                  ^ (INV & {WIDTH{in_signed == MODE_SIGNED}});
      assign pp[i] = {{WIDTH{1'b0}}, bits} << i;
   end

   assign pp[WIDTH] = (in_signed == MODE_SIGNED) ? BW_K : '0;

   for (genvar l = 0; l < NL; l++) begin : g_lay
      localparam int N = rows_at(WIDTH, l);
      localparam int G = N / 3;
      localparam int M = rows_at(WIDTH, l + 1);

      logic [PW-1:0] prv  [N];
      logic [PW-1:0] rin  [N];
      logic [PW-1:0] rout [M];

      for (genvar r = 0; r < N; r++) begin : g_src
         if (l == 0) begin : g_first
            assign prv[r] = pp[r];
         end else begin : g_next
            assign prv[r] = g_lay[l-1].rout[r];
         end
      end

      if (is_cut(WIDTH, STAGES, l)) begin : g_cut
         always_ff @(posedge clk) begin
            if (adv) rin <= prv;
         end
      end else begin : g_thru
         assign rin = prv;
      end

      for (genvar g = 0; g < G; g++) begin : g_csa
         csa_row #(.N(PW)) u_csa (
            .a_i   (rin[3*g]),
            .b_i   (rin[3*g+1]),
            .c_i   (rin[3*g+2]),
            .sum_o (rout[2*g]),
            .cry_o (rout[2*g+1])
         );
      end

      for (genvar r = 0; r < N % 3; r++) begin : g_pass
         assign rout[2*G+r] = rin[3*G+r];
      end
   end

   assign prod_d = g_lay[NL-1].rout[0] + g_lay[NL-1].rout[1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v_q    <= '0;
         tag_q  <= '0;
         prod_q <= '0;
      end else if (adv) begin
         v_q   <= v_d;
         tag_q <= tag_d;
         if (v_d[STAGES-1]) prod_q <= prod_d;
      end
   end

   assign out_valid = v_q[STAGES-1];
   assign out_tag   = tag_q[STAGES-1];
   assign out_prod  = prod_q;
   assign busy      = |v_q;

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Directed self-checking bench for wallace_mult_pipe at WIDTH=32, STAGES=3.
// Expected products below are hand-computed.
module tb_wallace_mult_pipe;

   localparam int W  = 32;
   localparam int S  = 3;
   localparam int TW = 4;
   localparam int NA = 9;

   localparam logic          AR_SGN [NA] = '{
      1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
   localparam logic [31:0]   AR_A   [NA] = '{
      32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000,
      32'h80000000, 32'h80000000, 32'h7FFFFFFF, 32'h12345678,
      32'hFFFFFFFD};
   localparam logic [31:0]   AR_B   [NA] = '{
      32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000005, 32'h80000000,
      32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h00000010,
      32'h00000005};
   localparam logic [63:0]   AR_EXP [NA] = '{
      64'hFFFFFFFE00000001, 64'h0000000000000001,
      64'hFFFFFFFFFFFFFFF1, 64'h4000000000000000,
      64'h7FFFFFFF80000000, 64'h0000000080000000,
      64'hC000000080000000, 64'h0000000123456780,
      64'h00000004FFFFFFF1};

   localparam int BP_TAG [13] = '{
      -1, -1, -1, 0, 1, 1, 1, 1, 1, 2, 3, 4, -1};

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic            in_signed;
   logic [W-1:0]    in_a;
   logic [W-1:0]    in_b;
   logic [TW-1:0]   in_tag;
   logic            out_valid;
   logic            out_ready;
   logic [2*W-1:0]  out_prod;
   logic [TW-1:0]   out_tag;
   logic            busy;

   int tests;
   int fails;

   wallace_mult_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(TW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_signed (in_signed),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_prod  (out_prod),
      .out_tag   (out_tag),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_signed = 1'b0;
      in_a = '0;
      in_b = '0;
      in_tag = '0;
      out_ready = 1'b1;
      tick();
      tick();
      tests++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_valid: out_valid=%b busy=%b want 0 0",
                  out_valid, busy);
      end
      tests++;
      if (out_prod !== 64'h0 || out_tag !== 4'h0) begin
         fails++;
         $display("FAIL reset_data: prod=%h tag=%h want 0 0",
                  out_prod, out_tag);
      end
      rst_n = 1'b1;
      out_ready = 1'b0;
      #1;
      tests++;
      if (in_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
      out_ready = 1'b1;
      tick();
   endtask

   task automatic test_latency;
      logic [31:0] a [3];
      logic [31:0] b [3];
      logic [63:0] e [3];
      a = '{32'h400, 32'h803, 32'h802};
      b = '{32'h1, 32'h1, 32'h2};
      e = '{64'h400, 64'h803, 64'h1004};
      for (int c = 0; c < 6; c++) begin
         in_valid = (c < 3);
         in_signed = 1'b0;
         if (c < 3) begin
            in_a = a[c];
            in_b = b[c];
            in_tag = 4'(c);
         end
         tick();
         tests++;
         if (c < 2 || c == 5) begin
            if (out_valid !== 1'b0) begin
               fails++;
               $display("FAIL lat_idle c=%0d: out_valid=%b want 0",
                        c, out_valid);
            end
         end else if (out_valid !== 1'b1 || out_prod !== e[c-2]) begin
            fails++;
            $display("FAIL lat_out c=%0d: valid=%b prod=%h want 1 %h",
                     c, out_valid, out_prod, e[c-2]);
         end
      end
   endtask

   task automatic test_arith;
      for (int c = 0; c < NA + 3; c++) begin
         in_valid = (c < NA);
         if (c < NA) begin
            in_signed = AR_SGN[c];
            in_a = AR_A[c];
            in_b = AR_B[c];
            in_tag = 4'(c);
         end
         tick();
         if (c >= 2 && c < NA + 2) begin
            tests++;
            if (out_valid !== 1'b1 || out_prod !== AR_EXP[c-2]
                || out_tag !== 4'(c - 2)) begin
               fails++;
               $display("FAIL arith_%0d: v=%b prod=%h tag=%h want 1 %h %h",
                        c - 2, out_valid, out_prod, out_tag,
                        AR_EXP[c-2], 4'(c - 2));
            end
         end else if (c == NA + 2) begin
            tests++;
            if (out_valid !== 1'b0) begin
               fails++;
               $display("FAIL arith_drain: out_valid=%b want 0", out_valid);
            end
         end
      end
   endtask

   task automatic test_back_pressure;
      int sent;
      logic exp_rdy;
      logic [63:0] exp_p;
      sent = 0;
      for (int c = 0; c < 13; c++) begin
         out_ready = !(c >= 4 && c <= 7);
         in_valid = (sent < 5);
         in_signed = 1'b0;
         in_a = 32'(sent + 1);
         in_b = 32'd3;
         in_tag = 4'(sent);
         #1;
         exp_rdy = !(c >= 4 && c <= 7);
         tests++;
         if (in_ready !== exp_rdy) begin
            fails++;
            $display("FAIL bp_ready c=%0d: in_ready=%b want %b",
                     c, in_ready, exp_rdy);
         end
         tests++;
         if (BP_TAG[c] < 0) begin
            if (out_valid !== 1'b0) begin
               fails++;
               $display("FAIL bp_idle c=%0d: out_valid=%b want 0",
                        c, out_valid);
            end
         end else begin
            exp_p = 64'((BP_TAG[c] + 1) * 3);
            if (out_valid !== 1'b1 || out_tag !== 4'(BP_TAG[c])
                || out_prod !== exp_p) begin
               fails++;
               $display("FAIL bp_out c=%0d: v=%b tag=%h prod=%h want 1 %h %h",
                        c, out_valid, out_tag, out_prod,
                        4'(BP_TAG[c]), exp_p);
            end
         end
         if (in_valid && in_ready) sent++;
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tests++;
      if (sent != 5) begin
         fails++;
         $display("FAIL bp_sent: accepted %0d want 5", sent);
      end
   endtask

   task automatic test_reset_mid;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_signed = 1'b0;
         in_a = 32'(i + 2);
         in_b = 32'd5;
         in_tag = 4'(8 + i);
         tick();
      end
      in_valid = 1'b0;
      tests++;
      if (busy !== 1'b1 || out_valid !== 1'b1 || out_prod !== 64'd10) begin
         fails++;
         $display("FAIL rm_before: busy=%b v=%b prod=%h want 1 1 a",
                  busy, out_valid, out_prod);
      end
      rst_n = 1'b0;
      tick();
      tests++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_prod !== 64'h0
          || out_tag !== 4'h0) begin
         fails++;
         $display("FAIL rm_after: v=%b busy=%b prod=%h tag=%h want 0 0 0 0",
                  out_valid, busy, out_prod, out_tag);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         tests++;
         if (out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rm_stale k=%0d: v=%b busy=%b want 0 0",
                     k, out_valid, busy);
         end
      end
      in_valid = 1'b1;
      in_signed = 1'b1;
      in_a = 32'd7;
      in_b = 32'd6;
      in_tag = 4'd5;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tests++;
         if (k < 2) begin
            if (out_valid !== 1'b0) begin
               fails++;
               $display("FAIL rm_lat k=%0d: out_valid=%b want 0",
                        k, out_valid);
            end
         end else if (out_valid !== 1'b1 || out_prod !== 64'd42
                      || out_tag !== 4'd5) begin
            fails++;
            $display("FAIL rm_next: v=%b prod=%h tag=%h want 1 2a 5",
                     out_valid, out_prod, out_tag);
         end
         tick();
      end
      tests++;
      if (out_valid !== 1'b0) begin
         fails++;
         $display("FAIL rm_drain: out_valid=%b want 0", out_valid);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_latency();
      test_arith();
      test_back_pressure();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
